// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage initiator. Turns a load/store command into word-aligned,
//            byte-strobed req/ack transactions, steers store lanes, extends
//            load results and stalls the pipeline until the access completes.
// Option   : define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into
//            two transactions; otherwise they are rejected with a misalign
//            pulse and no bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              stall,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [31:0]       read_data_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic              split_q;
    logic [3:0]        strb_hi_q;
    logic [31:0]       rbuf_q;
    logic [3:0]        w_strb_hi;
`else
    logic              misalign_q;
`endif

    logic        w_legal;
    logic        w_crossing;
    logic [1:0]  w_lane;
    logic [3:0]  w_strb_base;
    logic [3:0]  w_strb_lo;
    logic [31:0] w_rep;
    logic [31:0] w_rot;
    logic [63:0] w_ld_pair;
    logic [31:0] w_ld_raw;
    logic [31:0] w_ld_ext;

    assign w_lane = address[1:0];

    // Command decode: legality, access size, store replication and crossing detect
    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~MemWrite;   // unsigned forms exist for loads only
            default:                w_legal = 1'b0;
        endcase
        w_strb_base = 4'b1111;
        w_rep       = writeData;
        case (funct3[1:0])
            2'b00: begin
                w_strb_base = 4'b0001;
                w_rep       = {4{writeData[7:0]}};
            end
            2'b01: begin
                w_strb_base = 4'b0011;
                w_rep       = {2{writeData[15:0]}};
            end
            default: begin
                w_strb_base = 4'b1111;
                w_rep       = writeData;
            end
        endcase
        w_crossing = ((funct3[1:0] == 2'b01) && (w_lane == 2'b11)) ||
                     ((funct3[1:0] == 2'b10) && (w_lane != 2'b00));
    end

    // Strobes for the first word; overflow lanes belong to the following word.
    assign w_strb_lo = w_strb_base << w_lane;
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_strb_hi = w_strb_base >> (3'd4 - {1'b0, w_lane});
`endif

    // Rotating the replicated data left by the lane puts byte k of the operand
    // on lane (lane+k) mod 4, which is correct for both words of a split access.
    assign w_rot = 32'({w_rep, w_rep} >> (6'd32 - {1'b0, w_lane, 3'b000}));

    // Load result: gather the addressed bytes from one or two words, then extend
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        w_ld_pair = (state_q == ACC1) ? {mem_rdata, rbuf_q} : {32'd0, mem_rdata};
`else
        w_ld_pair = {32'd0, mem_rdata};
`endif
        w_ld_raw = 32'(w_ld_pair >> {lane_q, 3'b000});
        case (f3_q)
            3'b000:  w_ld_ext = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
            3'b001:  w_ld_ext = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
            3'b100:  w_ld_ext = {24'd0, w_ld_raw[7:0]};
            3'b101:  w_ld_ext = {16'd0, w_ld_raw[15:0]};
            default: w_ld_ext = w_ld_raw;
        endcase
    end

    // Access sequencer with registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            f3_q        <= 3'd0;
            lane_q      <= 2'd0;
            read_data_q <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            strb_hi_q   <= 4'd0;
            rbuf_q      <= 32'd0;
`else
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemRead | MemWrite) begin
                        f3_q   <= funct3;
                        lane_q <= w_lane;
                        if (!w_legal) begin
                            state_q <= DONE;
                        end
`ifndef LSU_MISALIGN_SPLIT_EN
                        else if (w_crossing) begin
                            state_q    <= DONE;
                            misalign_q <= 1'b1;
                        end
`endif
                        else begin
                            state_q     <= ACC0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MemWrite;
                            mem_addr_q  <= {address[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= MemWrite ? w_rot : 32'd0;
                            mem_wstrb_q <= MemWrite ? w_strb_lo : 4'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
                            split_q     <= w_crossing;
                            strb_hi_q   <= MemWrite ? w_strb_hi : 4'd0;
`endif
                        end
                    end
                end
                ACC0: begin
                    if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (split_q) begin
                            // Keep req high; only address and strobes move on.
                            rbuf_q      <= mem_rdata;
                            mem_addr_q  <= mem_addr_q + ADDR_W'(4);
                            mem_wstrb_q <= strb_hi_q;
                            state_q     <= ACC1;
                        end else
`endif
                        begin
                            mem_req_q <= 1'b0;
                            if (!mem_we_q) read_data_q <= w_ld_ext;
                            state_q   <= DONE;
                        end
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ACC1: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) read_data_q <= w_ld_ext;
                        state_q   <= DONE;
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
`ifndef LSU_MISALIGN_SPLIT_EN
                    misalign_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = (MemRead | MemWrite) & (state_q != DONE);
    assign readData  = read_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    assign misalign  = 1'b0;
`else
    assign misalign  = misalign_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. Expected bus requests and
//            load results are queued when a command is driven and compared
//            against what the design produces.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] writeData = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] readData;
    logic        stall;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int passed = 0;
    int total = 0;
    int timeouts = 0;
    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [31:0] exp_rd_q[$];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .address(address), .writeData(writeData),
        .readData(readData), .stall(stall), .misalign(misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Drives one command and acts as the memory responder until stall drops.
    // Records requests (write data/strobes only for writes) into obs_q.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] r0, input logic [31:0] r1, input int waits,
                             output int stalls, output int reqs, output bit mis, output bit unstable);
        int   w;
        int   idx;
        bit   have_snap;
        bit   finished;
        txn_t snap;
        txn_t raw;
        stalls = 0; reqs = 0; mis = 1'b0; unstable = 1'b0;
        w = 0; idx = 0; have_snap = 1'b0; finished = 1'b0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; address = a; writeData = wd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (misalign) mis = 1'b1;
            if (!stall) begin
                finished = 1'b1;
                break;
            end
            stalls++;
            mem_ack = 1'b0;
            if (mem_req) begin
                raw = {mem_we, mem_addr, mem_wdata, mem_wstrb};
                if (!have_snap) begin
                    snap = raw;
                    have_snap = 1'b1;
                end else if (raw !== snap) begin
                    unstable = 1'b1;
                end
                if (w == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (idx == 0) ? r0 : r1;
                    obs_q.push_back(mem_we ? raw : {1'b0, mem_addr, 32'd0, 4'd0});
                    idx++; reqs++; w = 0; have_snap = 1'b0;
                end else begin
                    w++;
                end
            end
            @(negedge clk);
        end
        if (!finished) timeouts++;
        MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++; if (readData !== 32'd0) $display("FAIL rst_readData: got %h want %h", readData, 32'd0); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else passed++;
        total++; if (mem_addr !== 32'd0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passed++;
        total++; if (mem_wdata !== 32'd0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else passed++;
        total++; if (mem_wstrb !== 4'd0) $display("FAIL rst_mem_wstrb: got %b want 0000", mem_wstrb); else passed++;
        total++; if (misalign !== 1'b0) $display("FAIL rst_misalign: got %b want 0", misalign); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_sw_zero_wait();
        int st, rq; bit ms, us; txn_t e, o;
        exp_q.push_back({1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111});
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 32'd0, 0, st, rq, ms, us);
        total++; if (st != 2) $display("FAIL sw_stall_cycles: got %0d want 2", st); else passed++;
        total++; if (rq != 1) $display("FAIL sw_req_count: got %0d want 1", rq); else passed++;
        total++; if (ms) $display("FAIL sw_misalign: got 1 want 0"); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL sw_txn: got none want %h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL sw_txn: got %h want %h", o, e); else passed++; end
        end
        obs_q.delete();
    endtask

    task automatic test_lb_lbu();
        int st, rq; bit ms, us; txn_t e, o; logic [31:0] er;
        exp_q.push_back({1'b0, 32'h10, 32'd0, 4'd0});
        exp_rd_q.push_back(32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 3'b000, 32'h13, 32'd0, 32'h8012_3456, 32'd0, 0, st, rq, ms, us);
        er = exp_rd_q.pop_front(); total++;
        if (readData !== er) $display("FAIL lb_lane3: got %h want %h", readData, er); else passed++;
        exp_q.push_back({1'b0, 32'h10, 32'd0, 4'd0});
        exp_rd_q.push_back(32'h0000_0080);
        do_access(1'b1, 1'b0, 3'b100, 32'h13, 32'd0, 32'h8012_3456, 32'd0, 0, st, rq, ms, us);
        er = exp_rd_q.pop_front(); total++;
        if (readData !== er) $display("FAIL lbu_lane3: got %h want %h", readData, er); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL lb_txn: got none want %h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL lb_txn: got %h want %h", o, e); else passed++; end
        end
        obs_q.delete();
    endtask

    task automatic test_sh_lane2();
        int st, rq; bit ms, us; txn_t e, o;
        exp_q.push_back({1'b1, 32'h10, 32'hABCD_ABCD, 4'b1100});
        do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_ABCD, 32'd0, 32'd0, 0, st, rq, ms, us);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL sh_txn: got none want %h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL sh_txn: got %h want %h", o, e); else passed++; end
        end
        obs_q.delete();
    endtask

    task automatic test_wait_states();
        int st, rq; bit ms, us; txn_t e, o; logic [31:0] er;
        exp_q.push_back({1'b0, 32'h04, 32'd0, 4'd0});
        exp_rd_q.push_back(32'hFFFF_F00D);
        do_access(1'b1, 1'b0, 3'b001, 32'h04, 32'd0, 32'h1234_F00D, 32'd0, 3, st, rq, ms, us);
        total++; if (st != 5) $display("FAIL wait_stall_cycles: got %0d want 5", st); else passed++;
        total++; if (us) $display("FAIL wait_stable: got unstable want stable"); else passed++;
        er = exp_rd_q.pop_front(); total++;
        if (readData !== er) $display("FAIL wait_lh_data: got %h want %h", readData, er); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL wait_txn: got none want %h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL wait_txn: got %h want %h", o, e); else passed++; end
        end
        obs_q.delete();
    endtask

    task automatic test_lw_cross();
        int st, rq; bit ms, us; txn_t e, o; logic [31:0] er;
        // Establish a known readData first.
        exp_q.push_back({1'b0, 32'h20, 32'd0, 4'd0});
        exp_rd_q.push_back(32'h0BAD_F00D);
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 32'h0BAD_F00D, 32'd0, 0, st, rq, ms, us);
        er = exp_rd_q.pop_front(); total++;
        if (readData !== er) $display("FAIL lw_aligned: got %h want %h", readData, er); else passed++;
`ifdef LSU_MISALIGN_SPLIT_EN
        exp_q.push_back({1'b0, 32'h0C, 32'd0, 4'd0});
        exp_q.push_back({1'b0, 32'h10, 32'd0, 4'd0});
        exp_rd_q.push_back(32'h4433_2211);
        do_access(1'b1, 1'b0, 3'b010, 32'h0E, 32'd0, 32'h2211_9999, 32'h7777_4433, 0, st, rq, ms, us);
        total++; if (st != 3) $display("FAIL lwx_stall_cycles: got %0d want 3", st); else passed++;
        total++; if (ms) $display("FAIL lwx_misalign: got 1 want 0"); else passed++;
`else
        exp_rd_q.push_back(32'h0BAD_F00D);
        do_access(1'b1, 1'b0, 3'b010, 32'h0E, 32'd0, 32'h2211_9999, 32'h7777_4433, 0, st, rq, ms, us);
        total++; if (rq != 0) $display("FAIL lwx_no_req: got %0d requests want 0", rq); else passed++;
        total++; if (!ms) $display("FAIL lwx_misalign: got 0 want 1"); else passed++;
        total++; if (st != 1) $display("FAIL lwx_stall_cycles: got %0d want 1", st); else passed++;
`endif
        er = exp_rd_q.pop_front(); total++;
        if (readData !== er) $display("FAIL lwx_data: got %h want %h", readData, er); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL lwx_txn: got none want %h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL lwx_txn: got %h want %h", o, e); else passed++; end
        end
        total++; if (obs_q.size() != 0) $display("FAIL lwx_extra_txn: got %0d extra want 0", obs_q.size()); else passed++;
        obs_q.delete();
    endtask

    task automatic test_lanes();
        int st, rq; bit ms, us; txn_t e, o; logic [31:0] er; logic [7:0] b;
        for (int l = 0; l < 4; l++) begin
            b = 8'h10 + 8'(l);
            exp_q.push_back({1'b1, 32'h40, {4{b}}, 4'(1 << l)});
            do_access(1'b0, 1'b1, 3'b000, 32'h40 + 32'(l), {24'hFFFFFF, b}, 32'd0, 32'd0, l, st, rq, ms, us);
        end
        exp_q.push_back({1'b0, 32'h04, 32'd0, 4'd0});
        exp_rd_q.push_back(32'h0000_8001);
        do_access(1'b1, 1'b0, 3'b101, 32'h06, 32'd0, 32'h8001_0000, 32'd0, 1, st, rq, ms, us);
        er = exp_rd_q.pop_front(); total++;
        if (readData !== er) $display("FAIL lhu_lane2: got %h want %h", readData, er); else passed++;
        exp_q.push_back({1'b0, 32'h04, 32'd0, 4'd0});
        exp_rd_q.push_back(32'hFFFF_8001);
        do_access(1'b1, 1'b0, 3'b001, 32'h06, 32'd0, 32'h8001_0000, 32'd0, 0, st, rq, ms, us);
        er = exp_rd_q.pop_front(); total++;
        if (readData !== er) $display("FAIL lh_lane2: got %h want %h", readData, er); else passed++;
        // Illegal funct3: no traffic, result untouched.
        exp_rd_q.push_back(32'hFFFF_8001);
        do_access(1'b1, 1'b0, 3'b011, 32'h08, 32'd0, 32'h1111_1111, 32'd0, 0, st, rq, ms, us);
        total++; if (rq != 0) $display("FAIL illegal_no_req: got %0d requests want 0", rq); else passed++;
        er = exp_rd_q.pop_front(); total++;
        if (readData !== er) $display("FAIL illegal_data: got %h want %h", readData, er); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL lanes_txn: got none want %h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL lanes_txn: got %h want %h", o, e); else passed++; end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int st, rq; bit ms, us; txn_t e, o;
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; address = 32'h20;
        @(negedge clk); #1;
        total++; if (mem_req !== 1'b1) $display("FAIL rstmid_in_acc0: got %b want 1", mem_req); else passed++;
        reset = 1'b1; MemRead = 1'b0;
        @(negedge clk); #1;
        total++; if (mem_req !== 1'b0) $display("FAIL rstmid_req: got %b want 0", mem_req); else passed++;
        total++; if (readData !== 32'd0) $display("FAIL rstmid_readData: got %h want 0", readData); else passed++;
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b0) $display("FAIL late_ack_req: got %b want 0", mem_req); else passed++;
        total++; if (readData !== 32'd0) $display("FAIL late_ack_data: got %h want 0", readData); else passed++;
        exp_q.push_back({1'b1, 32'h00, 32'h5A5A_5A5A, 4'b0010});
        do_access(1'b0, 1'b1, 3'b000, 32'h01, 32'h0000_005A, 32'd0, 32'd0, 0, st, rq, ms, us);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL rstmid_sb_txn: got none want %h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL rstmid_sb_txn: got %h want %h", o, e); else passed++; end
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_sw_zero_wait();
        test_lb_lbu();
        test_sh_lane2();
        test_wait_states();
        test_lw_cross();
        test_lanes();
        test_reset_mid();
        total++;
        if (timeouts != 0) $display("FAIL access_timeout: got %0d timed-out accesses want 0", timeouts);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator for the pipelined RISC-V core. Converts the MEM stage's load/store command (`MemRead`/`MemWrite`/`funct3`/byte address) into word-aligned, byte-strobed request/acknowledge transactions toward a data memory responder. Performs byte-lane steering, load sign/zero extension and, optionally, splitting of word-crossing accesses. Stalls the pipeline until the access completes.

## Interface

- `ADDR_W`, 32, byte-address width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `MemRead`  in  1  load command from MEM stage
- `MemWrite`  in  1  store command; wins if both asserted
- `funct3`  in  3  access type (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- `address`  in  ADDR_W  byte address
- `writeData`  in  32  store data, right-justified
- `readData`  out  32  extended load result
- `stall`  out  1  freeze pipeline
- `misalign`  out  1  one-cycle pulse: word-crossing access rejected
- `mem_req`  out  1  transaction request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  word-aligned address, `[1:0]` = 00
- `mem_wdata`  out  32  lane-steered write data
- `mem_wstrb`  out  4  byte enables, bit n = byte lane n
- `mem_rdata`  in  32  read data, valid with `mem_ack`
- `mem_ack`  in  1  transaction complete

## Operation

- Little-endian byte order. Lane = `address[1:0]`.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE: a command (`MemRead|MemWrite`) latches the command, funct3, address and data, then moves to ACC0. Illegal funct3 moves directly to DONE with no bus traffic.
- ACC0: `mem_req` = 1 for the first (or only) word. On `mem_ack`, move to ACC1 if the access is split, else to DONE.
- ACC1: `mem_req` = 1 at word address +4. On `mem_ack`, move to DONE.
- DONE: `stall` = 0 for exactly one cycle, and `readData` is updated for loads. Return to IDLE.
- `stall` = `(MemRead|MemWrite) & (state != DONE)`, combinational.
- Store steering:
  - SB: `mem_wdata` = byte replicated x4; `wstrb` = `0001 << lane`.
  - SH: `mem_wdata` = half replicated x2; `wstrb` = `0011 << lane`.
  - SW: `mem_wdata` rotated left by 8·lane; `wstrb` = `1111 << lane`.
  - For SH and SW, strobe bits shifted past bit 3 go to the ACC1 transaction.
- Crossing access: LH/SH at lane 3, or LW/SW at lane ≠ 0. Half at lane 1 or 2 is a single transaction.
- Loads: bytes are collected from one or two `mem_rdata` words, then sign-extended (LB, LH) or zero-extended (LBU, LHU). `readData` holds its value between loads; stores never change it.
- Reset (any state): next edge forces IDLE. An `mem_ack` arriving in IDLE is ignored.

## Timing

- All outputs other than `stall` are registered.
- Reset values: `readData` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_wstrb` = 0, `misalign` = 0.
- `mem_req` rises the cycle after the command is seen in IDLE.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are stable while `mem_req` = 1 and `mem_ack` = 0.
- `mem_ack` is sampled only while `mem_req` = 1. It may arrive in the first request cycle (zero wait states).
- Minimum latency: single access, command seen at cycle 0, DONE at cycle 2. Split access reaches DONE at cycle 3. Each wait state adds one cycle.
- Between ACC0 and ACC1, `mem_req` stays high; only the address, strobe and data change.
- `mem_req` is 0 in DONE and IDLE.

## Configuration

- `LSU_MISALIGN_SPLIT_EN` defined: crossing accesses run ACC0 then ACC1. `misalign` is tied to 0.
- `LSU_MISALIGN_SPLIT_EN` undefined: a crossing access goes IDLE → DONE with no `mem_req`. `misalign` = 1 during DONE. `readData` is unchanged and memory is not modified. ACC1 is not synthesized.

## Test plan

- **SW, zero wait.** SW `0xDEADBEEF` @ `0x10`, ack in first request cycle. Required: `mem_addr` = `0x10`, `wstrb` = `1111`, `wdata` = `0xDEADBEEF`, `mem_we` = 1; `stall` high for 2 cycles.
- **LB / LBU at lane 3.** LB @ `0x13` with `mem_rdata` = `0x80123456` → `readData` = `0xFFFFFF80`. LBU at the same address → `0x00000080`.
- **SH at lane 2.** SH `0xABCD` @ `0x12` → `wstrb` = `1100`, `wdata` = `0xABCDABCD`, `mem_addr` = `0x10`.
- **LW crossing a word boundary.** LW @ `0x0E`.
  - With macro: first `mem_addr` = `0x0C`, rdata `0x2211xxxx`; second `mem_addr` = `0x10`, rdata `0xxxxx4433` → `readData` = `0x44332211`.
  - Without macro: no `mem_req`, `misalign` pulses once, `readData` unchanged.
- **Wait states.** LH @ `0x04` with ack delayed 3 cycles → `mem_req`, `mem_addr` and `wstrb` held stable; `stall` high for 5 cycles; `readData` is the sign-extended half.
- **Reset mid-access.** Assert `reset` in ACC0 → next cycle `mem_req` = 0 and `readData` = 0; a late `mem_ack` is ignored; a subsequent SB `0x5A` @ `0x01` gives `wstrb` = `0010` and `wdata` = `0x5A5A5A5A`.
